fpio_fifo_out_client: RTL and testbench

Synthesizable read-side client of the fpio FIFO interface: on a request for N words it pops N entries from an upstream FIFO and presents them on a valid/ready stream. It is the counterpart to the FIFO input client, which writes into the FIFO. A small prefetch buffer hides the FIFO's 1-cycle read latency, so it sustains one word per cycle.

---
 rtl/fpio_fifo_out_client_if.sv | 27 ++
 rtl/fpio_fifo_out_client.sv | 121 ++++++++++++
 tb/tb_fpio_fifo_out_client.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpio_fifo_out_client_if.sv
// Request, upstream FIFO read port and output stream of the fpio FIFO read-side client.
interface fpio_fifo_out_client_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   req_valid;
    logic [COUNT_WIDTH-1:0] req_count;
    logic                   req_ready;
    logic                   done;
    logic                   busy;
    logic                   fifo_empty;
    logic                   fifo_rd;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic [DATA_WIDTH-1:0]  dat_o;
    logic                   dat_valid;
    logic                   dat_ready;

    modport slave (
        input  req_valid, req_count, fifo_empty, fifo_rd_data, dat_ready,
        output req_ready, done, busy, fifo_rd, dat_o, dat_valid
    );

    modport master (
        output req_valid, req_count, fifo_empty, fifo_rd_data, dat_ready,
        input  req_ready, done, busy, fifo_rd, dat_o, dat_valid
    );
endinterface

// File: rtl/fpio_fifo_out_client.sv
// Read-side fpio FIFO client: pops req_count words from an upstream FIFO and streams them out.
// A prefetch buffer plus a bypass of the returning read data sustains one word per cycle.
module fpio_fifo_out_client #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input logic                   clk,
    input logic                   rstn,
    fpio_fifo_out_client_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   inflight_q;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0]  mem_q [BUF_DEPTH];
    logic                   done_q, done_d;

    logic       req_ready, accept, rd, dat_valid;
    logic       bypass, pop, push, pop_mem;
    logic [OCC_W:0] level, limit;

    // With the buffer empty, the word arriving from the FIFO is presented directly; if it is
    // consumed in that cycle it never enters the buffer.
    assign bypass    = inflight_q && (occ_q == '0);
    assign dat_valid = rstn && ((occ_q != '0) || inflight_q);
    assign pop       = dat_valid && bus.dat_ready;
    assign push      = inflight_q && !(bypass && pop);
    assign pop_mem   = pop && !bypass;
    assign occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop_mem);

    assign level = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
    assign limit = (OCC_W + 1)'(BUF_DEPTH) + (OCC_W + 1)'(pop);

    assign req_ready     = rstn && (state_q == ST_IDLE);
    assign accept        = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;
    assign bus.busy      = rstn && (state_q != ST_IDLE);
    assign bus.done      = rstn && done_q;
    assign bus.fifo_rd   = rd;
    assign bus.dat_valid = dat_valid;
    assign bus.dat_o     = !rstn ? '0 : (bypass ? bus.fifo_rd_data : mem_q[rd_ptr_q]);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        rd          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_count != '0) begin
                        remaining_d = bus.req_count;
                        state_d     = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                rd = rstn && !bus.fifo_empty && (remaining_q != '0) && (level < limit);
                if (rd) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Nothing is fetched here, so occ_d == 0 also implies the last read has landed.
                if (occ_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= rd;
            occ_q       <= occ_d;
            done_q      <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_mem) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.fifo_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (occ_q <= OCC_W'(BUF_DEPTH));
        end
    end
endmodule

// File: tb/tb_fpio_fifo_out_client.sv
// Bench for fpio_fifo_out_client: an upstream FIFO model feeds the DUT, expected words are queued
// as stimulus is loaded and popped as the stream delivers them.
module tb_fpio_fifo_out_client;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fpio_fifo_out_client_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    fpio_fifo_out_client #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .BUF_DEPTH(BD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_q[$];

    // Upstream FIFO: one-cycle read latency, writes become visible one cycle after loading.
    always @(posedge clk) begin
        if (bus.fifo_rd && fifo_q.size() != 0) bus.fifo_rd_data <= fifo_q.pop_front();
        while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int first, input int n, input bit expect_it);
        for (int i = 0; i < n; i++) begin
            wr_q.push_back(DW'(first + i));
            if (expect_it) exp_q.push_back(DW'(first + i));
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] w;
        rstn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_count = '0;
        bus.dat_ready = 1'b0;
        repeat (3) cycle();
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.fifo_rd, bus.dat_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got done/busy/rd/valid=%b want 0000",
                     {bus.done, bus.busy, bus.fifo_rd, bus.dat_valid});
        end
        w = bus.dat_o;
        n_cmp++;
        if (w !== '0) begin
            n_bad++; $display("FAIL reset_dat_o: got %0h want 0", w);
        end
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
        end
        cycle();
    endtask

    task automatic test_basic();
        logic [15:0] rd_seen = '0;
        int first_k = -1;
        int done_k = -1;
        int ndone = 0;
        logic [DW-1:0] e;
        load(32'h10, 4, 1'b1);
        cycle(); cycle();
        bus.dat_ready = 1'b1;
        bus.req_count = CW'(4);
        bus.req_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_accept: got req_ready=%b want 1", bus.req_ready);
        end
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            rd_seen[k] = bus.fifo_rd;
            if (bus.dat_valid && bus.dat_ready) begin
                if (first_k < 0) first_k = k;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL basic_data: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            if (bus.done) begin
                ndone++;
                done_k = k;
            end
            cycle();
        end
        n_cmp++;
        if (rd_seen !== 16'h001e) begin
            n_bad++; $display("FAIL basic_fifo_rd: got cycles %b want %b", rd_seen, 16'h001e);
        end
        n_cmp++;
        if (first_k != 2) begin
            n_bad++; $display("FAIL basic_latency: got first word at %0d want 2", first_k);
        end
        n_cmp++;
        if (ndone != 1 || done_k != 6) begin
            n_bad++; $display("FAIL basic_done: got %0d pulses at %0d want 1 at 6", ndone, done_k);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL basic_count: got %0d words left want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int outstanding = 0;
        int ndone = 0;
        bit held = 1'b0;
        logic [DW-1:0] held_val = '0;
        logic [DW-1:0] e;
        bit pop;
        load(32'h20, 6, 1'b1);
        cycle(); cycle();
        bus.dat_ready = 1'b1;
        bus.req_count = CW'(6);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 40 && ndone == 0; k++) begin
            bus.dat_ready = (k % 3 == 1);
            #1;
            pop = bus.dat_valid && bus.dat_ready;
            if (bus.fifo_rd) begin
                n_cmp++;
                if (outstanding >= BD + int'(pop)) begin
                    n_bad++;
                    $display("FAIL bp_overfetch: cycle %0d rd with %0d outstanding pop=%0b",
                             k, outstanding, pop);
                end
            end
            if (held) begin
                n_cmp++;
                if (bus.dat_valid !== 1'b1 || bus.dat_o !== held_val) begin
                    n_bad++;
                    $display("FAIL bp_stable: cycle %0d got valid=%b data=%0h want 1 %0h",
                             k, bus.dat_valid, bus.dat_o, held_val);
                end
            end
            if (pop) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL bp_data: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            outstanding = outstanding + int'(bus.fifo_rd) - int'(pop);
            n_cmp++;
            if (outstanding > BD) begin
                n_bad++; $display("FAIL bp_occupancy: got %0d want <= %0d", outstanding, BD);
            end
            held = bus.dat_valid && !bus.dat_ready;
            held_val = bus.dat_o;
            if (bus.done) ndone++;
            cycle();
        end
        n_cmp++;
        if (ndone != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_complete: got done=%0d left=%0d want 1 0", ndone, exp_q.size());
        end
        bus.dat_ready = 1'b1;
    endtask

    task automatic test_empty_fifo();
        int ndone = 0;
        logic [DW-1:0] e;
        load(32'h30, 1, 1'b1);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        cycle(); cycle();
        bus.dat_ready = 1'b1;
        bus.req_count = CW'(3);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) load(32'h31, 2, 1'b0);
            #1;
            if (bus.fifo_rd) begin
                n_cmp++;
                if (bus.fifo_empty !== 1'b0) begin
                    n_bad++; $display("FAIL empty_rd: cycle %0d got fifo_rd=1 want 0 while empty", k);
                end
            end
            if (bus.dat_valid && bus.dat_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL empty_data: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            if (bus.done) ndone++;
            cycle();
        end
        n_cmp++;
        if (ndone != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL empty_complete: got done=%0d left=%0d want 1 0", ndone, exp_q.size());
        end
    endtask

    task automatic test_zero_count();
        // Words for the mid-operation reset test; they also make a spurious read observable here.
        load(32'h40, 12, 1'b0);
        cycle(); cycle();
        bus.dat_ready = 1'b1;
        bus.req_count = '0;
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (bus.done !== (k == 1) || bus.fifo_rd !== 1'b0 || bus.dat_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_count: cycle %0d got done/rd/valid=%b%b%b want %0b00",
                         k, bus.done, bus.fifo_rd, bus.dat_valid, (k == 1));
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        int npop = 0;
        int ndone = 0;
        logic [DW-1:0] e;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        bus.dat_ready = 1'b1;
        bus.req_count = CW'(8);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 12 && npop < 3; k++) begin
            #1;
            if (bus.dat_valid && bus.dat_ready) begin
                npop++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL mrst_data: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            cycle();
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.done, bus.busy, bus.fifo_rd, bus.dat_valid} !== 5'b0 ||
            bus.dat_o !== '0) begin
            n_bad++;
            $display("FAIL mrst_outputs: got ready/done/busy/rd/valid=%b data=%0h want 00000 0",
                     {bus.req_ready, bus.done, bus.busy, bus.fifo_rd, bus.dat_valid}, bus.dat_o);
        end
        cycle();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (bus.done !== 1'b0 || bus.dat_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mrst_quiet: cycle %0d got done/valid/busy=%b%b%b want 000",
                         k, bus.done, bus.dat_valid, bus.busy);
            end
            cycle();
        end
        // Four words were fetched before the reset; the fourth is lost with the buffer.
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h45);
        bus.req_count = CW'(2);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (bus.dat_valid && bus.dat_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL mrst_next: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            if (bus.done) ndone++;
            cycle();
        end
        n_cmp++;
        if (ndone != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL mrst_complete: got done=%0d left=%0d want 1 0", ndone, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int idle = 0;
        bit release_req;
        logic [DW-1:0] e;
        for (int i = 0; i < 5; i++) exp_q.push_back(DW'(8'h46 + i));
        bus.dat_ready = 1'b1;
        bus.req_count = CW'(2);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 40 && ndone < 2; k++) begin
            release_req = 1'b0;
            #1;
            if (bus.dat_valid && bus.dat_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (bus.dat_o !== e) begin
                    n_bad++; $display("FAIL b2b_data: cycle %0d got %0h want %0h", k, bus.dat_o, e);
                end
            end
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    n_cmp++;
                    if (bus.req_ready !== 1'b1) begin
                        n_bad++; $display("FAIL b2b_ready: got req_ready=%b want 1", bus.req_ready);
                    end
                    bus.req_count = CW'(3);
                    bus.req_valid = 1'b1;
                    release_req = 1'b1;
                end
            end
            if (ndone < 2 && !bus.busy) idle++;
            cycle();
            if (release_req) bus.req_valid = 1'b0;
        end
        n_cmp++;
        if (ndone != 2 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_complete: got done=%0d left=%0d want 2 0", ndone, exp_q.size());
        end
        n_cmp++;
        if (idle != 1) begin
            n_bad++; $display("FAIL b2b_idle: got %0d idle cycles want 1", idle);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_fifo();
        test_zero_count();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within 200000 time units want completion");
        $fatal(1);
    end
endmodule
